// File: rtl/csa_slice_sequencer.sv
// Sequences a WIDTH-bit add through an external 4-bit carry select adder, one nibble per cycle.
// Optional subtract mode is built when CSA_SLICE_SUB_EN is defined (adds input port in_sub).
module csa_slice_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
`ifdef CSA_SLICE_SUB_EN
   input  logic             in_sub,
`endif
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_s,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] sum_next;
   logic [IW-1:0]    idx;
   logic             carry;
   logic             sub_reg;
   logic             sub_in;
   logic             accept;

`ifdef CSA_SLICE_SUB_EN
   assign sub_in = in_sub;
`else
   assign sub_in = 1'b0;
`endif

   assign accept = in_valid & in_ready;

   // Ready is live in IDLE, follows the consumer in DONE, and is forced low while in reset.
   always_comb begin
      in_ready = 1'b0;
      if (rst) begin
         in_ready = 1'b0;
      end else begin
         case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
         endcase
      end
   end

   // Drive the external adder only while a slice is in flight; subtract inverts the b slice.
   always_comb begin
      add_a   = 4'd0;
      add_b   = 4'd0;
      add_cin = 1'b0;
      if (state == RUN) begin
         add_a   = a_reg[{idx, 2'b00} +: 4];
         add_b   = b_reg[{idx, 2'b00} +: 4] ^ {4{sub_reg}};
         add_cin = carry;
      end else begin
         add_a   = 4'd0;
         add_b   = 4'd0;
         add_cin = 1'b0;
      end
   end

   // Partial sum with the current slice merged in, so the final slice can go straight to out_sum.
   always_comb begin
      sum_next = sum_reg;
      sum_next[{idx, 2'b00} +: 4] = add_s;
   end

   // Sequencer state, operand capture and the registered result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         sub_reg   <= 1'b0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state <= RUN;
               end
            end
            RUN: begin
               sum_reg <= sum_next;
               carry   <= add_cout;
               if (idx == LAST) begin
                  state     <= DONE;
                  idx       <= '0;
                  out_valid <= 1'b1;
                  out_sum   <= sum_next;
                  out_cout  <= add_cout;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= in_valid ? RUN : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Capture overrides the RUN bookkeeping; it only happens from IDLE or a retiring DONE.
         if (accept) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            sub_reg <= sub_in;
            idx     <= '0;
            carry   <= sub_in ? 1'b1 : in_cin;
         end
      end
   end

endmodule

// File: tb/tb_csa_slice_sequencer.sv
// Scoreboard bench for csa_slice_sequencer with a behavioural 4-bit adder; define CSA_SLICE_SUB_EN for subtract vectors.
`timescale 1ns/1ps
module tb_csa_slice_sequencer;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic             in_cin = 1'b0;
`ifdef CSA_SLICE_SUB_EN
   logic             in_sub = 1'b0;
`endif
   logic [3:0]       add_a;
   logic [3:0]       add_b;
   logic             add_cin;
   logic [3:0]       add_s;
   logic             add_cout;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   csa_slice_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef CSA_SLICE_SUB_EN
      .in_sub(in_sub),
`endif
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout)
   );

   always #5 clk = ~clk;

   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      int               cyc;
   } exp_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        c;
   } vec_t;

   vec_t vecs [7] = '{
      '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0},
      '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1},
      '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1},
      '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0},
      '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1},
      '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0},
      '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0}
   };

   exp_t sb[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   presented = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every cycle a result is presented it is checked against the scoreboard head.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         presented = 1'b0;
      end else if (out_valid) begin
         if (sb.size() == 0) begin
            chk("valid_without_request", {31'd0, out_valid}, 32'd0);
         end else begin
            if (!presented) begin
               chk("latency", cyc - sb[0].cyc, 32'd5);
               presented = 1'b1;
            end
            chk("out_sum", {16'd0, out_sum}, {16'd0, sb[0].sum});
            chk("out_cout", {31'd0, out_cout}, {31'd0, sb[0].cout});
            chk("in_ready_in_done", {31'd0, in_ready}, {31'd0, out_ready});
            chk("adder_idle_in_done", {23'd0, add_a, add_b, add_cin}, 32'd0);
            if (out_ready) begin
               sb.delete(0);
               presented = 1'b0;
            end
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic [15:0] es, input logic ec, output int acc);
      exp_t e;
      int   n;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", {31'd0, in_ready}, 32'd1);
         acc = -1;
      end else begin
         e.sum  = es;
         e.cout = ec;
         e.cyc  = cyc;
         sb.push_back(e);
         acc = cyc;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("drain_timeout", sb.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      int acc0;
      int acc1;
      int n;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_sum", {16'd0, out_sum}, 32'd0);
      chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
      chk("rst_adder", {23'd0, add_a, add_b, add_cin}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, acc);
         in_valid = 1'b0;
         drain();
      end

      // Consumer stall: result must hold for three cycles with in_ready low.
      out_ready = 1'b0;
      send(16'h2468, 16'h1357, 1'b0, 16'h37BF, 1'b0, acc);
      in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      repeat (3) @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post_handshake_valid", {31'd0, out_valid}, 32'd0);
      chk("post_handshake_ready", {31'd0, in_ready}, 32'd1);
      drain();

      // Back-to-back: in_valid held high across three operands.
      send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, acc0);
      send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, acc1);
      chk("b2b_spacing_1", acc1 - acc0, 32'd5);
      send(16'hFFFE, 16'h0001, 1'b1, 16'h0000, 1'b1, acc);
      chk("b2b_spacing_2", acc - acc1, 32'd5);
      in_valid = 1'b0;
      drain();

      // Reset while the third slice is being processed.
      send(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, acc);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrun_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrun_rst_out_sum", {16'd0, out_sum}, 32'd0);
      chk("midrun_rst_adder", {23'd0, add_a, add_b, add_cin}, 32'd0);
      chk("midrun_rst_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("midrun_no_valid", {31'd0, out_valid}, 32'd0);
      chk("midrun_idle_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      send(16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, acc);
      in_valid = 1'b0;
      drain();

`ifdef CSA_SLICE_SUB_EN
      in_sub = 1'b1;
      send(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, acc);
      in_valid = 1'b0;
      drain();
      send(16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, acc);
      in_valid = 1'b0;
      drain();
      in_sub = 1'b0;
      send(16'h0007, 16'h0005, 1'b0, 16'h000C, 1'b0, acc);
      in_valid = 1'b0;
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
